// File: rtl/mem_resp_pkg.sv
// Shared types and default sizes for the memory request responder.
//   state_t : responder FSM states
//   op_t    : latched operation kind
//   DEF_*   : default word width / RAM address width; PORT_ADDR_W is the
//             fixed width of the PC/addr request buses
package mem_resp_pkg;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 10;
    localparam int PORT_ADDR_W = 16;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/mem_request_responder_if.sv
// Request/response bundle between the control unit (master) and the
// memory responder (slave).
//   master drives : PC, fetch_req, MemRead, MemWrite, addr, datain
//   slave drives  : instr, dataout, fetch_done, data_done, busy
interface mem_request_responder_if import mem_resp_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);
    logic [PORT_ADDR_W-1:0] PC;
    logic                   fetch_req;
    logic                   MemRead;
    logic                   MemWrite;
    logic [PORT_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      datain;
    logic [DATA_W-1:0]      instr;
    logic [DATA_W-1:0]      dataout;
    logic                   fetch_done;
    logic                   data_done;
    logic                   busy;

    modport master (
        output PC, fetch_req, MemRead, MemWrite, addr, datain,
        input  instr, dataout, fetch_done, data_done, busy
    );

    modport slave (
        input  PC, fetch_req, MemRead, MemWrite, addr, datain,
        output instr, dataout, fetch_done, data_done, busy
    );
endinterface

// File: rtl/sync_ram_1p.sv
// Single-port RAM: synchronous write, registered read. No reset, so the
// contents survive a responder reset.
//   clk   : clock
//   we    : write addr with wdata at this edge
//   re    : register mem[addr] into rdata at this edge
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module sync_ram_1p import mem_resp_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_request_responder.sv
// Memory-side responder: serves instruction fetches and data reads/writes
// against one single-port RAM through an IDLE/WAIT/ACCESS/RESP FSM with
// WAIT_CYCLES extra wait states. Priority MemWrite > MemRead > fetch_req;
// requests are only sampled in IDLE and never queued.
//   CLK, RST_N : clock, async active-low reset
//   bus        : slave side of mem_request_responder_if (requests in,
//                instr/dataout/done pulses/busy out, all registered)
// ADDR_W must be below PORT_ADDR_W; upper request address bits are dropped
// so addresses wrap modulo 2^ADDR_W.
module mem_request_responder import mem_resp_pkg::*; #(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    mem_request_responder_if.slave   bus
);
    state_t            state, state_nxt;
    op_t               op_q, req_op;
    logic [ADDR_W-1:0] addr_q, req_addr;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        cnt_q;
    logic              req_any;

    logic [DATA_W-1:0] instr_q, dataout_q, rdata;
    logic              fetch_done_q, data_done_q, busy_q;

    logic ram_we, ram_re;

    // Upper address bits are intentionally ignored (address wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.PC[PORT_ADDR_W-1:ADDR_W], bus.addr[PORT_ADDR_W-1:ADDR_W]};

    // Fixed-priority request select.
    always_comb begin
        req_any  = bus.MemWrite | bus.MemRead | bus.fetch_req;
        req_op   = OP_FETCH;
        req_addr = bus.PC[ADDR_W-1:0];
        if (bus.MemWrite) begin
            req_op   = OP_WRITE;
            req_addr = bus.addr[ADDR_W-1:0];
        end else if (bus.MemRead) begin
            req_op   = OP_READ;
            req_addr = bus.addr[ADDR_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            WAIT:    if (cnt_q <= 3'd1) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and wait counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q    <= OP_FETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else if (state == IDLE && req_any) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= bus.datain;
            cnt_q   <= 3'(WAIT_CYCLES);
        end else if (state == WAIT) begin
            cnt_q   <= cnt_q - 3'd1;
        end
    end

    // The RAM is only touched in ACCESS, so a reset before then drops a
    // pending write without corrupting storage.
    assign ram_we = (state == ACCESS) && (op_q == OP_WRITE);
    assign ram_re = (state == ACCESS) && (op_q != OP_WRITE);

    sync_ram_1p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    // Output registers: results land on the RESP edge, done pulses last
    // exactly one cycle, busy tracks the registered next state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            instr_q      <= '0;
            dataout_q    <= '0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            busy_q       <= (state_nxt != IDLE);
            if (state == RESP) begin
                case (op_q)
                    OP_FETCH: begin
                        instr_q      <= rdata;
                        fetch_done_q <= 1'b1;
                    end
                    OP_READ: begin
                        dataout_q    <= rdata;
                        data_done_q  <= 1'b1;
                    end
                    default: data_done_q <= 1'b1;
                endcase
            end
        end
    end

    assign bus.instr      = instr_q;
    assign bus.dataout    = dataout_q;
    assign bus.fetch_done = fetch_done_q;
    assign bus.data_done  = data_done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_request_responder.sv
// Directed, table-driven bench for mem_request_responder (WAIT_CYCLES=1,
// ADDR_W=10) plus hand sequences for arbitration and mid-access reset.
module tb_mem_request_responder;
    import mem_resp_pkg::*;

    localparam int W   = 1;
    localparam int LAT = W + 3;  // posedges from the driving negedge to done

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mem_request_responder_if #(.DATA_W(16)) bus();

    mem_request_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_CYCLES(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int nf = 0;
    int nd = 0;

    always @(negedge CLK) begin
        if (bus.fetch_done) nf++;
        if (bus.data_done)  nd++;
    end

    typedef struct {
        op_t         op;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;  // instr for fetches, dataout otherwise
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts posedges until the selected done pulse is seen (-1 on timeout).
    task automatic wait_done(input bit fetch, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (fetch ? bus.fetch_done : bus.data_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic xact(input op_t op, input logic [15:0] a, input logic [15:0] d, output int lat);
        @(negedge CLK);
        bus.PC        = a;
        bus.addr      = a;
        bus.datain    = d;
        bus.fetch_req = (op == OP_FETCH);
        bus.MemRead   = (op == OP_READ);
        bus.MemWrite  = (op == OP_WRITE);
        wait_done(op == OP_FETCH, lat);
        bus.fetch_req = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, bf, bd;
        time tprev;

        tbl[0]  = '{OP_WRITE, 16'h0005, 16'hBEEF, 16'h0000};
        tbl[1]  = '{OP_READ,  16'h0005, 16'h0000, 16'hBEEF};
        tbl[2]  = '{OP_WRITE, 16'h0000, 16'h1000, 16'hBEEF};
        tbl[3]  = '{OP_WRITE, 16'h0001, 16'h1001, 16'hBEEF};
        tbl[4]  = '{OP_WRITE, 16'h0002, 16'h1002, 16'hBEEF};
        tbl[5]  = '{OP_WRITE, 16'h0003, 16'h1003, 16'hBEEF};
        tbl[6]  = '{OP_FETCH, 16'h0000, 16'h0000, 16'h1000};
        tbl[7]  = '{OP_FETCH, 16'h0001, 16'h0000, 16'h1001};
        tbl[8]  = '{OP_FETCH, 16'h0002, 16'h0000, 16'h1002};
        tbl[9]  = '{OP_FETCH, 16'h0003, 16'h0000, 16'h1003};
        tbl[10] = '{OP_WRITE, 16'h0403, 16'h1234, 16'hBEEF};
        tbl[11] = '{OP_READ,  16'h0003, 16'h0000, 16'h1234};
        tbl[12] = '{OP_WRITE, 16'h0007, 16'h5555, 16'h1234};

        bus.PC = '0; bus.addr = '0; bus.datain = '0;
        bus.fetch_req = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst instr",      32'(bus.instr),      32'h0);
        chk("rst dataout",    32'(bus.dataout),    32'h0);
        chk("rst fetch_done", 32'(bus.fetch_done), 32'h0);
        chk("rst data_done",  32'(bus.data_done),  32'h0);
        chk("rst busy",       32'(bus.busy),       32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("idle busy",  32'(bus.busy), 32'h0);
        chk("idle dones", 32'(nf + nd),  32'h0);

        // Table-driven transactions
        tprev = 0;
        for (int i = 0; i < 13; i++) begin
            xact(tbl[i].op, tbl[i].a, tbl[i].d, lat);
            chk($sformatf("row%0d latency", i), 32'(lat), 32'(LAT));
            if (lat > 0) begin
                if (tbl[i].op == OP_FETCH)
                    chk($sformatf("row%0d instr", i), 32'(bus.instr), 32'(tbl[i].exp));
                else
                    chk($sformatf("row%0d dataout", i), 32'(bus.dataout), 32'(tbl[i].exp));
                chk($sformatf("row%0d busy at done", i), 32'(bus.busy), 32'h0);
                if (tbl[i].op == OP_FETCH) begin
                    if (i > 6)
                        chk($sformatf("row%0d fetch spacing", i), 32'($time - tprev), 32'd40);
                    tprev = $time;
                end
            end
        end
        @(negedge CLK); #1;
        chk("fetch pulse count", 32'(nf), 32'd4);
        chk("data pulse count",  32'(nd), 32'd9);

        // Arbitration: all three requests together
        bf = nf; bd = nd;
        @(negedge CLK);
        bus.PC = 16'h0002; bus.addr = 16'h0010; bus.datain = 16'hCAFE;
        bus.fetch_req = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b1;
        wait_done(1'b0, lat);
        chk("arb write latency", 32'(lat), 32'(LAT));
        chk("arb write dataout", 32'(bus.dataout), 32'h1234);
        chk("arb write no fetch", 32'(bus.fetch_done), 32'h0);
        bus.MemWrite = 1'b0;
        wait_done(1'b0, lat);
        chk("arb read latency", 32'(lat), 32'(LAT));
        chk("arb read dataout", 32'(bus.dataout), 32'hCAFE);
        bus.MemRead = 1'b0;
        wait_done(1'b1, lat);
        chk("arb fetch latency", 32'(lat), 32'(LAT));
        chk("arb fetch instr", 32'(bus.instr), 32'h1002);
        bus.fetch_req = 1'b0;
        @(negedge CLK); #1;
        chk("arb data pulses",  32'(nd - bd), 32'd2);
        chk("arb fetch pulses", 32'(nf - bf), 32'd1);

        // Reset while the write is in WAIT
        bd = nd;
        @(negedge CLK);
        bus.addr = 16'h0007; bus.datain = 16'hAAAA; bus.MemWrite = 1'b1;
        @(posedge CLK); #1;
        chk("mid busy in WAIT", 32'(bus.busy), 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid rst instr",     32'(bus.instr),     32'h0);
        chk("mid rst dataout",   32'(bus.dataout),   32'h0);
        chk("mid rst busy",      32'(bus.busy),      32'h0);
        chk("mid rst data_done", 32'(bus.data_done), 32'h0);
        bus.MemWrite = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(posedge CLK); #1;
        chk("mid no data_done", 32'(nd - bd), 32'd0);
        xact(OP_READ, 16'h0007, 16'h0000, lat);
        chk("mid read latency", 32'(lat), 32'(LAT));
        chk("mid read old value", 32'(bus.dataout), 32'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
